// File: rtl/synapse_accumulator.sv
// Time-multiplexed binary-weight synapse accumulator: sums LANES spike x (+/-1) terms
// per cycle and returns the signed dot product and active-spike count of one vector.
module synapse_accumulator #(
    parameter int N_INPUTS = 32,
    parameter int LANES    = 8,
    parameter int SUM_W    = $clog2(N_INPUTS + 1) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_INPUTS-1:0]     spikes,
    input  logic [N_INPUTS-1:0]     weights,
    input  logic                    abort,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [SUM_W-1:0] out_sum,
    output logic [SUM_W-1:0]        out_active
);

    localparam int BEATS  = N_INPUTS / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic signed [SUM_W-1:0] TERM_POS = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] TERM_NEG = '1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t state, state_next;

    logic [N_INPUTS-1:0]     spikes_p0;
    logic [N_INPUTS-1:0]     weights_p0;
    logic [BEAT_W-1:0]       beat_p0;
    logic signed [SUM_W-1:0] acc_sum_p1;
    logic [SUM_W-1:0]        acc_active_p1;

    logic [LANES-1:0]        lane_spikes;
    logic [LANES-1:0]        lane_weights;
    logic signed [SUM_W-1:0] beat_sum;
    logic [SUM_W-1:0]        beat_active;
    logic signed [SUM_W-1:0] next_sum;
    logic [SUM_W-1:0]        next_active;
    logic                    accept;
    logic                    last_beat;

    // Silent synapses contribute nothing; a firing one adds +1 or -1 by its weight bit.
    function automatic logic signed [SUM_W-1:0] lane_term_sum(
        input logic [LANES-1:0] s,
        input logic [LANES-1:0] w
    );
        logic signed [SUM_W-1:0] total;
        total = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s[i]) begin
                total = w[i] ? (total + TERM_POS) : (total + TERM_NEG);
            end
        end
        return total;
    endfunction

    function automatic logic [SUM_W-1:0] lane_popcount(input logic [LANES-1:0] s);
        logic [SUM_W-1:0] count;
        count = '0;
        for (int i = 0; i < LANES; i++) begin
            count = count + SUM_W'(s[i]);
        end
        return count;
    endfunction

    assign lane_spikes  = spikes_p0[beat_p0 * LANES +: LANES];
    assign lane_weights = weights_p0[beat_p0 * LANES +: LANES];
    assign beat_sum     = lane_term_sum(lane_spikes, lane_weights);
    assign beat_active  = lane_popcount(lane_spikes);
    assign next_sum     = acc_sum_p1 + beat_sum;
    assign next_active  = acc_active_p1 + beat_active;
    assign last_beat    = (beat_p0 == LAST_BEAT);
    assign accept       = (state == IDLE) && in_valid && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ACCUM;
            end
            ACCUM: begin
                if (last_beat) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Cancellation overrides acceptance and consumption alike.
        if (abort) state_next = IDLE;
    end

    // p0: latched input vectors and beat index; p1: running sum/count; outputs held after DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spikes_p0     <= '0;
            weights_p0    <= '0;
            beat_p0       <= '0;
            acc_sum_p1    <= '0;
            acc_active_p1 <= '0;
            out_sum       <= '0;
            out_active    <= '0;
        end else if (abort) begin
            beat_p0       <= '0;
            acc_sum_p1    <= '0;
            acc_active_p1 <= '0;
        end else if (accept) begin
            spikes_p0     <= spikes;
            weights_p0    <= weights;
            beat_p0       <= '0;
            acc_sum_p1    <= '0;
            acc_active_p1 <= '0;
        end else if (state == ACCUM) begin
            acc_sum_p1    <= next_sum;
            acc_active_p1 <= next_active;
            if (last_beat) begin
                beat_p0    <= '0;
                out_sum    <= next_sum;
                out_active <= next_active;
            end else begin
                beat_p0 <= beat_p0 + BEAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_synapse_accumulator.sv
// Directed scoreboard bench for synapse_accumulator: an 8-input/2-lane build and an
// 8-input/8-lane build sharing one clock and reset.
module tb_synapse_accumulator;

    logic       clk = 1'b0;
    logic       reset;

    logic       in_valid, in_ready, abort, out_valid, out_ready;
    logic [7:0] spikes, weights;
    logic [4:0] out_sum, out_active;

    logic       in_valid_b, in_ready_b, abort_b, out_valid_b, out_ready_b;
    logic [7:0] spikes_b, weights_b;
    logic [4:0] out_sum_b, out_active_b;

    typedef struct packed {
        logic [4:0] sum;
        logic [4:0] act;
    } exp_t;

    exp_t       sb[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] rs, rw;
    bit         seen;

    synapse_accumulator #(.N_INPUTS(8), .LANES(2), .SUM_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .spikes(spikes), .weights(weights), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_active(out_active)
    );

    synapse_accumulator #(.N_INPUTS(8), .LANES(8), .SUM_W(5)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .spikes(spikes_b), .weights(weights_b), .abort(abort_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_sum(out_sum_b), .out_active(out_active_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: (+1 per spiking synapse with weight 1) minus (+1 per spiking synapse with weight 0).
    function automatic logic [4:0] model_sum(input logic [7:0] s, input logic [7:0] w);
        int pos, neg;
        pos = $countones(s & w);
        neg = $countones(s & ~w);
        return 5'(pos - neg);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit b, input logic [7:0] s, input logic [7:0] w,
                        input logic [4:0] es, input logic [4:0] ea);
        exp_t e;
        if (b) begin
            spikes_b = s; weights_b = w; in_valid_b = 1'b1;
            check("in_ready_b_before_accept", 32'(in_ready_b), 1);
        end else begin
            spikes = s; weights = w; in_valid = 1'b1;
            check("in_ready_before_accept", 32'(in_ready), 1);
        end
        e.sum = es;
        e.act = ea;
        sb.push_back(e);
        step();
        in_valid = 1'b0; in_valid_b = 1'b0;
        spikes = ~s; weights = ~w; spikes_b = ~s; weights_b = ~w;
    endtask

    task automatic collect(input bit b, input int exp_lat, input string tag, input int hold);
        int   lat;
        exp_t e;
        lat = 0;
        while (!(b ? out_valid_b : out_valid) && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
            e = '0;
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"}, 32'(b ? out_sum_b : out_sum), 32'(e.sum));
            check({tag, "_active"}, 32'(b ? out_active_b : out_active), 32'(e.act));
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            step();
            check({tag, "_hold_valid"}, 32'(out_valid), 1);
            check({tag, "_hold_sum"}, 32'(out_sum), 32'(e.sum));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        if (b) out_ready_b = 1'b1; else out_ready = 1'b1;
        step();
        out_ready = 1'b0; out_ready_b = 1'b0;
        check({tag, "_release_valid"}, 32'(b ? out_valid_b : out_valid), 0);
        check({tag, "_release_in_ready"}, 32'(b ? in_ready_b : in_ready), 1);
        check({tag, "_release_sum_kept"}, 32'(b ? out_sum_b : out_sum), 32'(e.sum));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; abort = 1'b0; abort_b = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; spikes = '0; weights = '0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; spikes_b = '0; weights_b = '0;
        #12;
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_sum", 32'(out_sum), 0);
        check("reset_out_active", 32'(out_active), 0);
        check("reset_out_valid_b", 32'(out_valid_b), 0);
        reset = 1'b0;
        step();

        // Single-synapse equivalence and zero-spike vectors
        send(0, 8'h01, 8'h00, 5'b11111, 5'd1); collect(0, 4, "x1_wneg", 0);
        send(0, 8'h01, 8'h01, 5'd1, 5'd1);     collect(0, 4, "x1_wpos", 0);
        send(0, 8'h00, 8'hA5, 5'd0, 5'd0);     collect(0, 4, "x0_wA5", 0);
        send(0, 8'h00, 8'hFF, 5'd0, 5'd0);     collect(0, 4, "x0_wFF", 0);
        send(0, 8'hF0, 8'hA5, 5'd0, 5'd4);     collect(0, 4, "mixed", 0);
        send(0, 8'hFF, 8'h00, 5'b11000, 5'd8); collect(0, 4, "all_neg", 0);
        send(0, 8'hFF, 8'hFF, 5'd8, 5'd8);     collect(0, 4, "all_pos", 0);
        send(0, 8'h80, 8'h00, 5'b11111, 5'd1); collect(0, 4, "top_lane", 0);

        for (int i = 0; i < 4; i++) begin
            rs = 8'($urandom);
            rw = 8'($urandom);
            send(0, rs, rw, model_sum(rs, rw), 5'($countones(rs)));
            collect(0, 4, "random", 0);
        end

        // Backpressure with in_valid held high during DONE
        send(0, 8'h0F, 8'h07, 5'd2, 5'd4); collect(0, 4, "backpressure", 5);
        step();
        check("bp_no_extra_accept", 32'(in_ready), 1);

        // Abort during beat 2
        spikes = 8'hFF; weights = 8'hFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_beat2_in_ready", 32'(in_ready), 1);
        check("abort_beat2_out_valid", 32'(out_valid), 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("abort_beat2_no_result", 32'(seen), 0);
        send(0, 8'h0F, 8'h07, 5'd2, 5'd4); collect(0, 4, "after_abort", 0);

        // Abort coincident with in_valid in IDLE
        spikes = 8'hFF; weights = 8'h00; in_valid = 1'b1; abort = 1'b1;
        step();
        in_valid = 1'b0; abort = 1'b0;
        check("abort_idle_in_ready", 32'(in_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("abort_idle_not_accepted", 32'(seen), 0);

        // Abort while a result waits in DONE
        spikes = 8'h55; weights = 8'h55; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("abort_done_reached", 32'(out_valid), 1);
        check("abort_done_sum", 32'(out_sum), 32'(5'd4));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_done_valid", 32'(out_valid), 0);
        check("abort_done_in_ready", 32'(in_ready), 1);

        // Single-beat build
        send(1, 8'h0F, 8'h03, 5'd0, 5'd4);     collect(1, 1, "l8_mixed", 0);
        send(1, 8'hFF, 8'h00, 5'b11000, 5'd8); collect(1, 1, "l8_all_neg", 0);

        // Asynchronous reset in the middle of ACCUM
        send(0, 8'hFF, 8'hFF, 5'd8, 5'd8); collect(0, 4, "pre_reset", 0);
        spikes = 8'h3C; weights = 8'h0F; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_out_valid", 32'(out_valid), 0);
        check("async_reset_out_sum", 32'(out_sum), 0);
        check("async_reset_out_active", 32'(out_active), 0);
        check("async_reset_in_ready", 32'(in_ready), 1);
        check("async_reset_out_sum_b", 32'(out_sum_b), 0);
        #2;
        reset = 1'b0;
        step();
        send(0, 8'hFF, 8'h00, 5'b11000, 5'd8); collect(0, 4, "after_reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
